gpio_host_arbiter: RTL and testbench
====================================

// Module: gpio_host_arbiter
// PURPOSE
//  Shares a single GPIO device port between NumHosts bus hosts (e.g. core data port, debug module).
//  Round-robin arbitration: at most one request reaches the device per cycle.
//  Responses return at a fixed latency. The arbiter tracks the host ID of each issued request
//  and steers device_rvalid_i/device_rdata_i back to the host that issued it.
//  Sits between the host crossbar and the gpio device port; the device side is a drop-in for the
//  existing device_* interface.
// PARAMETERS
//  NumHosts    2   number of requesting hosts (>=2)
//  AddrWidth   32  address width
//  DataWidth   32  data width
//  RspLatency  1   cycles from device_req_o to device_rvalid_i (>=1; gpio device = 1)
// PORTS
//  clk_i           in   1                    clock
//  rst_ni          in   1                    reset, asynchronous, active-low
//  host_req_i      in   [NumHosts]           request per host
//  host_addr_i     in   [NumHosts][AddrW]    request address
//  host_we_i       in   [NumHosts]           write enable
//  host_be_i       in   [NumHosts][4]        byte enables
//  host_wdata_i    in   [NumHosts][DataW]    write data
//  host_gnt_o      out  [NumHosts]           one-hot grant, same cycle as accepted req
//  host_rvalid_o   out  [NumHosts]           response valid, routed to issuing host
//  host_rdata_o    out  [NumHosts][DataW]    response data; '0 when that host's rvalid low
//  device_req_o    out  1                    request to gpio
//  device_addr_o   out  AddrW                muxed address
//  device_we_o     out  1                    muxed write enable
//  device_be_o     out  4                    muxed byte enables
//  device_wdata_o  out  DataW                muxed write data
//  device_rvalid_i in   1                    gpio response valid
//  device_rdata_i  in   DataW                gpio response data
//  rsp_err_o       out  1                    1-cycle pulse: rvalid with no matching pending entry
// BEHAVIOUR
//  - Grant is combinational: device_req_o = |host_req_i; exactly one host_gnt_o high when any req.
//  - Host rule: host holds req/addr/we/be/wdata stable until gnt; other outputs must not depend on gnt.
//  - Priority pointer ptr_q (reset 0): search starts at ptr_q, ascending index with wrap.
//    On grant to host g: ptr_q <= (g+1) mod NumHosts. No grant: ptr_q holds.
//  - Fairness: a continuously requesting host is granted within NumHosts cycles.
//  - Device mux: device_* fields taken from the granted host; '0 when no request.
//  - Pending tracker: RspLatency-deep shift register of {valid, host_id}, advances every cycle.
//    Stage 0 loads {device_req_o, g}.
//  - Response: when device_rvalid_i and last stage valid, host_rvalid_o[id]=1,
//    host_rdata_o[id]=device_rdata_i, same cycle (zero added latency).
//    rvalid applies to writes too; it carries rdata as driven by the device.
//  - Back-to-back: a new grant every cycle is allowed; the tracker handles RspLatency in flight.
//  - Error cases, each giving a rsp_err_o pulse:
//    - rvalid with last stage invalid: nothing forwarded.
//    - last stage valid without rvalid: entry dropped, no host response.
//  - Reset (any time): ptr_q=0, tracker cleared, rsp_err_o=0.
//    host_gnt_o/device_req_o follow host_req_i combinationally.
//    In-flight responses arriving after reset are flagged as rsp_err_o, not forwarded.
//  - host_id width = $clog2(NumHosts); NumHosts not power of 2: wrap explicit, never index >= NumHosts.
// STRUCTURE
//  - gpio_arb_pkg:
//    - typedef dev_req_t = struct packed {addr, we, be[3:0], wdata}, 32-bit fields.
//    - function rr_next(ptr, gnt).
//  - Sub-module rr_arbiter #(N): req[N], one-hot gnt[N], gnt_idx, ptr register.
//    Reusable for other shared peripherals.
//  - Top: rr_arbiter + request mux + pending shift register + response demux.
// TESTING
//  1 Single host: host0 read addr 0x4, device returns 0xA5 next cycle
//    -> gnt[0] same cycle, host_rvalid_o[0]=1, rdata 0xA5; host1 rdata 0.
//  2 Both hosts req every cycle from reset -> grants alternate 0,1,0,1;
//    rvalid alternates one cycle later with matching IDs.
//  3 Host1 requests alone for 3 cycles, then both request -> first contended grant goes to host0
//    (ptr advanced to 0 after host1).
//  4 NumHosts=3, RspLatency=2, all req continuously -> grant 0,1,2,0;
//    each response lands at the issuing host 2 cycles later.
//  5 Spurious device_rvalid_i with no pending -> rsp_err_o pulse 1 cycle, no host_rvalid_o.
//  6 rst_ni low for 1 cycle with a request in flight -> no host_rvalid_o, rsp_err_o pulse,
//    ptr restarts at 0.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared types and helpers for the GPIO host arbiter.
//   dev_req_t : one request as seen on the gpio device port (32-bit addr/wdata, 4 byte enables).
//   rr_next   : round-robin pointer update used by rr_arbiter.
package gpio_arb_pkg;

  localparam int unsigned DevAddrWidth = 32;
  localparam int unsigned DevDataWidth = 32;
  localparam int unsigned DevBeWidth   = 4;

  typedef struct packed {
    logic [DevAddrWidth-1:0] addr;
    logic                    we;
    logic [DevBeWidth-1:0]   be;
    logic [DevDataWidth-1:0] wdata;
  } dev_req_t;

  // Next priority pointer: one past the winner, wrapping at n; unchanged when nobody won.
  function automatic int unsigned rr_next(int unsigned ptr, int unsigned gnt, logic gnt_vld,
                                          int unsigned n);
    int unsigned nxt;
    if (!gnt_vld) begin
      nxt = ptr;
    end else if (gnt + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = gnt + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter with a registered priority pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointer returns to 0)
//   req_i         : request per requester
//   gnt_o         : one-hot grant, combinational from req_i and the pointer
//   gnt_idx_o     : index of the granted requester (0 when none)
//   gnt_vld_o     : at least one request present
module rr_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  localparam int unsigned SumW = IdxW + 1;

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] ptr_d;
  logic [SumW-1:0] sum_s;
  logic [IdxW-1:0] cand_s;
  logic [IdxW-1:0] idx_s;
  logic            found_s;

  // Scan from the pointer upward; the wrap is done by subtraction so a non-power-of-two N
  // never produces an index >= N.
  always_comb begin
    sum_s   = '0;
    cand_s  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      sum_s   = {1'b0, ptr_q} + SumW'(off);
      cand_s  = (sum_s >= SumW'(N)) ? IdxW'(sum_s - SumW'(N)) : IdxW'(sum_s);
      idx_s   = (req_i[cand_s] && !found_s) ? cand_s : idx_s;
      found_s = found_s | req_i[cand_s];
    end
  end

  // One-hot grant from the winning index.
  always_comb begin
    gnt_o        = '0;
    gnt_o[idx_s] = found_s;
  end

  assign gnt_idx_o = idx_s;
  assign gnt_vld_o = found_s;
  assign ptr_d     = IdxW'(rr_next(32'(ptr_q), 32'(idx_s), found_s, N));

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gpio_host_arbiter.sv
// Shares one gpio device port between NumHosts bus hosts.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   host_*_i           : per-host request (req/addr/we/be/wdata), held stable until granted
//   host_gnt_o         : one-hot grant, same cycle as the accepted request
//   host_rvalid_o/rdata: device response steered to the host that issued the request
//   device_*_o         : request of the granted host ('0 when idle)
//   device_rvalid_i/rdata_i : gpio response, RspLatency cycles after device_req_o
//   rsp_err_o          : registered 1-cycle pulse when rvalid and the oldest pending slot disagree
module gpio_host_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NumHosts   = 2,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned RspLatency = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumHosts-1:0]                 host_req_i,
  input  logic [NumHosts-1:0][AddrWidth-1:0]  host_addr_i,
  input  logic [NumHosts-1:0]                 host_we_i,
  input  logic [NumHosts-1:0][3:0]            host_be_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]  host_wdata_i,
  output logic [NumHosts-1:0]                 host_gnt_o,
  output logic [NumHosts-1:0]                 host_rvalid_o,
  output logic [NumHosts-1:0][DataWidth-1:0]  host_rdata_o,
  output logic                                device_req_o,
  output logic [AddrWidth-1:0]                device_addr_o,
  output logic                                device_we_o,
  output logic [3:0]                          device_be_o,
  output logic [DataWidth-1:0]                device_wdata_o,
  input  logic                                device_rvalid_i,
  input  logic [DataWidth-1:0]                device_rdata_i,
  output logic                                rsp_err_o
);

  localparam int unsigned IdW = $clog2(NumHosts);

  logic [IdW-1:0]                  gnt_idx_s;
  logic                            gnt_vld_s;
  dev_req_t                        dev_req_s;
  logic [RspLatency-1:0]           trk_vld_q;
  logic [RspLatency-1:0][IdW-1:0]  trk_id_q;
  logic                            last_vld_s;
  logic [IdW-1:0]                  last_id_s;
  logic                            rsp_err_q;

  rr_arbiter #(
    .N    (NumHosts),
    .IdxW (IdW)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (host_req_i),
    .gnt_o     (host_gnt_o),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // Forward the granted host's request fields; all zero when nobody requests.
  always_comb begin
    dev_req_s = '0;
    if (gnt_vld_s) begin
      dev_req_s.addr  = DevAddrWidth'(host_addr_i[gnt_idx_s]);
      dev_req_s.we    = host_we_i[gnt_idx_s];
      dev_req_s.be    = host_be_i[gnt_idx_s];
      dev_req_s.wdata = DevDataWidth'(host_wdata_i[gnt_idx_s]);
    end else begin
      dev_req_s = '0;
    end
  end

  assign device_req_o   = gnt_vld_s;
  assign device_addr_o  = AddrWidth'(dev_req_s.addr);
  assign device_we_o    = dev_req_s.we;
  assign device_be_o    = dev_req_s.be;
  assign device_wdata_o = DataWidth'(dev_req_s.wdata);

  // Pending tracker: one {valid, host id} slot per cycle of device latency, shifting every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_vld_q <= '0;
      trk_id_q  <= '0;
    end else begin
      trk_vld_q[0] <= gnt_vld_s;
      trk_id_q[0]  <= gnt_idx_s;
      for (int i = 1; i < int'(RspLatency); i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_id_q[i]  <= trk_id_q[i-1];
      end
    end
  end

  assign last_vld_s = trk_vld_q[RspLatency-1];
  assign last_id_s  = trk_id_q[RspLatency-1];

  // Steer the response to its issuer in the same cycle; unmatched responses are not forwarded.
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    if (device_rvalid_i && last_vld_s) begin
      host_rvalid_o[last_id_s] = 1'b1;
      host_rdata_o[last_id_s]  = device_rdata_i;
    end else begin
      host_rvalid_o = '0;
      host_rdata_o  = '0;
    end
  end

  // Flag a spurious response or a missing one (expected slot without rvalid).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= device_rvalid_i ^ last_vld_s;
    end
  end

  assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_gpio_host_arbiter.sv
// Self-checking bench: two arbiter instances (2 hosts/latency 1 and 3 hosts/latency 2) driven
// with directed phases and random traffic, compared each cycle against a cycle-indexed model.
module tb_gpio_host_arbiter;

  localparam int NI     = 2;
  localparam int MAXC   = 1024;
  localparam int M_IDLE = 0;
  localparam int M_H0   = 1;
  localparam int M_H1   = 2;
  localparam int M_ALL  = 3;
  localparam int M_SPUR = 4;
  localparam int M_RAND = 5;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  // stimulus, sized for the largest instance (3 hosts)
  logic [2:0]       req   [NI];
  logic [2:0][31:0] addr  [NI];
  logic [2:0]       we    [NI];
  logic [2:0][3:0]  be    [NI];
  logic [2:0][31:0] wdata [NI];
  logic             dev_rv [NI];
  logic [31:0]      dev_rd [NI];

  // instance A outputs
  logic [1:0] a_gnt, a_rv;
  logic [1:0][31:0] a_rd;
  logic a_dreq, a_dwe, a_err;
  logic [31:0] a_daddr, a_dwd;
  logic [3:0] a_dbe;
  // instance B outputs
  logic [2:0] b_gnt, b_rv;
  logic [2:0][31:0] b_rd;
  logic b_dreq, b_dwe, b_err;
  logic [31:0] b_daddr, b_dwd;
  logic [3:0] b_dbe;

  gpio_host_arbiter #(.NumHosts(2), .AddrWidth(32), .DataWidth(32), .RspLatency(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_req_i(req[0][1:0]), .host_addr_i(addr[0][1:0]), .host_we_i(we[0][1:0]),
    .host_be_i(be[0][1:0]), .host_wdata_i(wdata[0][1:0]),
    .host_gnt_o(a_gnt), .host_rvalid_o(a_rv), .host_rdata_o(a_rd),
    .device_req_o(a_dreq), .device_addr_o(a_daddr), .device_we_o(a_dwe),
    .device_be_o(a_dbe), .device_wdata_o(a_dwd),
    .device_rvalid_i(dev_rv[0]), .device_rdata_i(dev_rd[0]), .rsp_err_o(a_err)
  );

  gpio_host_arbiter #(.NumHosts(3), .AddrWidth(32), .DataWidth(32), .RspLatency(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_req_i(req[1]), .host_addr_i(addr[1]), .host_we_i(we[1]),
    .host_be_i(be[1]), .host_wdata_i(wdata[1]),
    .host_gnt_o(b_gnt), .host_rvalid_o(b_rv), .host_rdata_o(b_rd),
    .device_req_o(b_dreq), .device_addr_o(b_daddr), .device_we_o(b_dwe),
    .device_be_o(b_dbe), .device_wdata_o(b_dwd),
    .device_rvalid_i(dev_rv[1]), .device_rdata_i(dev_rd[1]), .rsp_err_o(b_err)
  );

  // uniform views of both instances
  logic [2:0]       o_gnt [NI];
  logic [2:0]       o_rv  [NI];
  logic [2:0][31:0] o_rd  [NI];
  logic             o_dreq [NI], o_dwe [NI], o_err [NI];
  logic [31:0]      o_daddr [NI], o_dwd [NI];
  logic [3:0]       o_dbe [NI];
  assign o_gnt[0] = {1'b0, a_gnt};  assign o_gnt[1] = b_gnt;
  assign o_rv[0]  = {1'b0, a_rv};   assign o_rv[1]  = b_rv;
  assign o_rd[0]  = {32'h0, a_rd};  assign o_rd[1]  = b_rd;
  assign o_dreq[0] = a_dreq;  assign o_dreq[1] = b_dreq;
  assign o_dwe[0]  = a_dwe;   assign o_dwe[1]  = b_dwe;
  assign o_err[0]  = a_err;   assign o_err[1]  = b_err;
  assign o_daddr[0] = a_daddr; assign o_daddr[1] = b_daddr;
  assign o_dwd[0]  = a_dwd;   assign o_dwd[1]  = b_dwd;
  assign o_dbe[0]  = a_dbe;   assign o_dbe[1]  = b_dbe;

  // reference model state
  int          ptr      [NI];
  int          issued   [NI][MAXC];    // host granted in cycle c and accepted by the edge, -1 none
  bit          rv_sched [NI][MAXC+4];  // device model: response due in cycle c
  logic [31:0] rd_sched [NI][MAXC+4];
  bit          err_exp  [NI];
  bit          hold     [NI][3];
  int          g_cur    [NI];
  int          last_cur [NI];

  int cyc;
  int mode;
  int rst_cycles;
  bit force_a5;
  int n_checks;
  int n_fail;

  function automatic int nh(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int lat(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic check_eq(string tag, logic [95:0] act, logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      for (int h = 0; h < nh(i); h++) begin
        if (!hold[i][h]) begin
          case (mode)
            M_H0:    req[i][h] = (h == 0);
            M_H1:    req[i][h] = (h == 1);
            M_ALL:   req[i][h] = 1'b1;
            M_RAND:  req[i][h] = ($urandom_range(0, 1) == 1);
            default: req[i][h] = 1'b0;
          endcase
          addr[i][h]  = (mode == M_H0) ? 32'h4 : $urandom();
          we[i][h]    = (mode == M_H0) ? 1'b0 : 1'($urandom_range(0, 1));
          be[i][h]    = 4'($urandom());
          wdata[i][h] = $urandom();
        end
      end
      dev_rv[i] = rv_sched[i][cyc];
      dev_rd[i] = rv_sched[i][cyc] ? rd_sched[i][cyc] : $urandom();
      if (mode == M_SPUR) dev_rv[i] = 1'b1;
      else if (mode == M_RAND && $urandom_range(0, 19) == 0) dev_rv[i] = ~dev_rv[i];
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      int n;
      int g;
      int last;
      logic [2:0]       exp_gnt;
      logic [2:0]       exp_rv;
      logic [2:0][31:0] exp_rd;
      n = nh(i);
      g = -1;
      for (int k = 0; k < n; k++) begin
        int h;
        h = (ptr[i] + k) % n;
        if (g < 0 && req[i][h]) g = h;
      end
      exp_gnt = (g >= 0) ? (3'b001 << g) : 3'b000;
      check_eq($sformatf("i%0d_gnt", i), 96'(o_gnt[i]), 96'(exp_gnt));
      check_eq($sformatf("i%0d_dreq", i), 96'(o_dreq[i]), 96'(g >= 0));
      check_eq($sformatf("i%0d_daddr", i), 96'(o_daddr[i]), 96'((g >= 0) ? addr[i][g] : 32'h0));
      check_eq($sformatf("i%0d_dwe", i), 96'(o_dwe[i]), 96'((g >= 0) ? we[i][g] : 1'b0));
      check_eq($sformatf("i%0d_dbe", i), 96'(o_dbe[i]), 96'((g >= 0) ? be[i][g] : 4'h0));
      check_eq($sformatf("i%0d_dwdata", i), 96'(o_dwd[i]), 96'((g >= 0) ? wdata[i][g] : 32'h0));
      last   = (cyc - lat(i) >= 1) ? issued[i][cyc - lat(i)] : -1;
      exp_rv = 3'b000;
      exp_rd = '0;
      if (dev_rv[i] && last >= 0) begin
        exp_rv[last] = 1'b1;
        exp_rd[last] = dev_rd[i];
      end
      check_eq($sformatf("i%0d_rvalid", i), 96'(o_rv[i]), 96'(exp_rv));
      check_eq($sformatf("i%0d_rdata", i), 96'(o_rd[i]), 96'(exp_rd));
      check_eq($sformatf("i%0d_rsp_err", i), 96'(o_err[i]), 96'(err_exp[i]));
      g_cur[i]    = g;
      last_cur[i] = last;
    end
  endtask

  task automatic update_model(bit in_reset);
    for (int i = 0; i < NI; i++) begin
      int g;
      g = g_cur[i];
      if (g >= 0) begin
        rv_sched[i][cyc + lat(i)] = 1'b1;
        rd_sched[i][cyc + lat(i)] = force_a5 ? 32'hA5 : $urandom();
      end
      if (in_reset) begin
        ptr[i]     = 0;
        err_exp[i] = 1'b0;
        for (int k = 0; k <= cyc; k++) issued[i][k] = -1;
      end else begin
        issued[i][cyc] = g;
        if (g >= 0) ptr[i] = (g + 1) % nh(i);
        err_exp[i] = dev_rv[i] ^ (last_cur[i] >= 0);
      end
      for (int h = 0; h < nh(i); h++) hold[i][h] = req[i][h] && (g != h);
    end
  endtask

  // One clock: drive after the rising edge, check and decide reset on the falling edge.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    check_outputs();
    if (rst_cycles > 0) begin
      rst_ni = 1'b0;
      rst_cycles--;
    end else begin
      rst_ni = 1'b1;
    end
    update_model(!rst_ni);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    force_a5 = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ptr[i] = 0;
      err_exp[i] = 1'b0;
      req[i] = '0; addr[i] = '0; we[i] = '0; be[i] = '0; wdata[i] = '0;
      dev_rv[i] = 1'b0; dev_rd[i] = '0;
      for (int h = 0; h < 3; h++) hold[i][h] = 1'b0;
      for (int k = 0; k < MAXC; k++) issued[i][k] = -1;
      for (int k = 0; k < MAXC + 4; k++) begin
        rv_sched[i][k] = 1'b0;
        rd_sched[i][k] = '0;
      end
    end
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;

    // reset state and idle
    mode = M_IDLE;
    rst_cycles = 2;
    repeat (3) run_cycle();

    // single host read of 0x4, device answers 0xA5
    mode = M_H0;
    force_a5 = 1'b1;
    run_cycle();
    check_eq("t1_gnt", 96'(a_gnt), 96'(2'b01));
    mode = M_IDLE;
    run_cycle();
    force_a5 = 1'b0;
    check_eq("t1_rvalid", 96'(a_rv), 96'(2'b01));
    check_eq("t1_rdata0", 96'(a_rd[0]), 96'(32'hA5));
    check_eq("t1_rdata1", 96'(a_rd[1]), 96'(32'h0));

    // all hosts request every cycle straight out of reset
    rst_cycles = 1;
    run_cycle();
    run_cycle();
    mode = M_ALL;
    run_cycle();
    check_eq("t2_first_gnt_a", 96'(a_gnt), 96'(2'b01));
    check_eq("t2_first_gnt_b", 96'(b_gnt), 96'(3'b001));
    run_cycle();
    check_eq("t2_second_gnt_a", 96'(a_gnt), 96'(2'b10));
    check_eq("t2_second_gnt_b", 96'(b_gnt), 96'(3'b010));
    repeat (6) run_cycle();

    // host1 alone, then contention: host0 wins first
    mode = M_IDLE;
    repeat (5) run_cycle();
    mode = M_H1;
    repeat (3) run_cycle();
    mode = M_ALL;
    run_cycle();
    check_eq("t3_contended_gnt", 96'(a_gnt), 96'(2'b01));
    repeat (3) run_cycle();

    // spurious device response
    mode = M_IDLE;
    repeat (6) run_cycle();
    mode = M_SPUR;
    run_cycle();
    check_eq("t5_no_rvalid", 96'(a_rv), 96'(2'b00));
    mode = M_IDLE;
    run_cycle();
    check_eq("t5_err_a", 96'(a_err), 96'(1'b1));
    check_eq("t5_err_b", 96'(b_err), 96'(1'b1));
    run_cycle();
    check_eq("t5_err_clear", 96'(a_err), 96'(1'b0));

    // reset pulse with a request in flight
    mode = M_H0;
    rst_cycles = 1;
    run_cycle();
    mode = M_IDLE;
    run_cycle();
    check_eq("t6_no_rvalid", 96'(a_rv), 96'(2'b00));
    run_cycle();
    check_eq("t6_err", 96'(a_err), 96'(1'b1));
    mode = M_ALL;
    run_cycle();
    check_eq("t6_ptr_restart", 96'(a_gnt), 96'(2'b01));
    mode = M_IDLE;
    repeat (4) run_cycle();

    // random traffic with injected response faults and occasional resets
    mode = M_RAND;
    repeat (400) begin
      if ($urandom_range(0, 63) == 0) rst_cycles = 1;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
